// File: rtl/spi_register_bank_if.sv
// Bus bundle between the SPI slave byte engine, fabric logic and spi_register_bank.
// The slave modport is the register bank's view; master is the driving side.
interface spi_register_bank_if #(
    parameter int ADDR_WIDTH = 4
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                    CS_i;
    logic [7:0]              RxData_i;
    logic                    RxDone_i;
    logic [7:0]              TxData_o;
    logic                    LocalWrite_i;
    logic [ADDR_WIDTH-1:0]   LocalAddr_i;
    logic [7:0]              LocalData_i;
    logic [8*DEPTH-1:0]      Registers_o;
    logic                    SpiWrite_o;
    logic [ADDR_WIDTH-1:0]   SpiAddr_o;
    logic                    Busy_o;
    logic                    Error_o;

    modport slave (
        input  CS_i, RxData_i, RxDone_i, LocalWrite_i, LocalAddr_i, LocalData_i,
        output TxData_o, Registers_o, SpiWrite_o, SpiAddr_o, Busy_o, Error_o
    );

    modport master (
        output CS_i, RxData_i, RxDone_i, LocalWrite_i, LocalAddr_i, LocalData_i,
        input  TxData_o, Registers_o, SpiWrite_o, SpiAddr_o, Busy_o, Error_o
    );
endinterface

// File: rtl/spi_register_bank.sv
// Turns the SPI slave byte stream into burst register reads/writes with address auto-increment.
// Optional SPI write protection above RO_BASE is enabled by defining SPI_REG_WRITE_PROTECT_EN.
module spi_register_bank #(
    parameter int         ADDR_WIDTH = 4,
    parameter logic [7:0] IDLE_BYTE  = 8'hA5,
    parameter int         RO_BASE    = 12
) (
    input logic               clk,
    input logic               srst,
    spi_register_bank_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    logic                  cs_meta_q, cs_sync_q, cs_prev_q;
    logic                  cs_fall, cs_rise;
    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [7:0]            tx_q, tx_d;
    logic                  spi_write_q, spi_write_d;
    logic [ADDR_WIDTH-1:0] spi_addr_q, spi_addr_d;
    logic                  error_q, error_d;
    logic                  spi_we;
    logic                  wr_protected;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            regs_q [DEPTH];

    // Idle-high reset value on the synchroniser avoids a phantom CS edge after reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            cs_prev_q <= 1'b1;
        end else begin
            cs_meta_q <= bus.CS_i;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
        end
    end

    assign cs_fall  = cs_prev_q & ~cs_sync_q;
    assign cs_rise  = ~cs_prev_q & cs_sync_q;
    assign cmd_addr = bus.RxData_i[ADDR_WIDTH-1:0];

`ifdef SPI_REG_WRITE_PROTECT_EN
    assign wr_protected = (int'({1'b0, ptr_q}) >= RO_BASE);
`else
    assign wr_protected = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        tx_d        = tx_q;
        spi_write_d = 1'b0;
        spi_addr_d  = spi_addr_q;
        error_d     = 1'b0;
        spi_we      = 1'b0;
        if (cs_rise) begin
            state_d = ST_IDLE;
            tx_d    = IDLE_BYTE;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall) state_d = ST_CMD;
                ST_CMD: begin
                    if (bus.RxDone_i) begin
                        if (bus.RxData_i[7]) begin
                            state_d = ST_READ;
                            tx_d    = regs_q[cmd_addr];
                            ptr_d   = cmd_addr + 1'b1;
                        end else begin
                            state_d = ST_WRITE;
                            ptr_d   = cmd_addr;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.RxDone_i) begin
                        ptr_d = ptr_q + 1'b1;
                        if (wr_protected) begin
                            error_d = 1'b1;
                        end else begin
                            spi_we      = 1'b1;
                            spi_write_d = 1'b1;
                            spi_addr_d  = ptr_q;
                        end
                    end
                end
                default: begin
                    if (bus.RxDone_i) begin
                        tx_d  = regs_q[ptr_q];
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            tx_q        <= IDLE_BYTE;
            spi_write_q <= 1'b0;
            spi_addr_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            tx_q        <= tx_d;
            spi_write_q <= spi_write_d;
            spi_addr_q  <= spi_addr_d;
            error_q     <= error_d;
        end
    end

    // SPI write takes precedence over a local write to the same address in the same cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        always_ff @(posedge clk) begin
            if (srst) begin
                regs_q[gi] <= 8'h00;
            end else if (spi_we && (ptr_q == ADDR_WIDTH'(gi))) begin
                regs_q[gi] <= bus.RxData_i;
            end else if (bus.LocalWrite_i && (bus.LocalAddr_i == ADDR_WIDTH'(gi))) begin
                regs_q[gi] <= bus.LocalData_i;
            end
        end
        assign bus.Registers_o[8*gi +: 8] = regs_q[gi];
    end

    assign bus.TxData_o   = tx_q;
    assign bus.SpiWrite_o = spi_write_q;
    assign bus.SpiAddr_o  = spi_addr_q;
    assign bus.Busy_o     = (state_q != ST_IDLE);
    assign bus.Error_o    = error_q;
endmodule
